// File: rtl/sirv_uart_txq_pkg.sv
// Shared UART queue constants.
// Used by the tx/rx queues and the register block so widths agree.
package sirv_uart_txq_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int UART_TXQ_DEPTH = 8;
  localparam int UART_RXQ_DEPTH = 8;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sirv_uart_txq.sv
// UART transmit queue: FWFT FIFO feeding sirv_uarttx, plus txdata
// full flag and tx watermark pending bit.
// Ports: clock/rst_n (sync, active low), io_flush, io_enq_* (write
// side), io_deq_* (head side), io_count, io_txcnt, io_full, io_ip_txwm.
module sirv_uart_txq
  import sirv_uart_txq_pkg::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH,
  parameter int WIDTH = UART_DATA_W,
  parameter int CNTW  = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             io_flush,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [CNTW-1:0]  io_count,
  input  logic [CNTW-2:0]  io_txcnt,
  output logic             io_full,
  output logic             io_ip_txwm
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic do_enq;
  logic do_deq;
  logic wr_en;

  // All handshake outputs derive from registered count only, so there
  // is no enq_valid->deq_valid or deq_ready->enq_ready path.
  assign io_full      = (count_q == CNT_FULL);
  assign io_enq_ready = ~io_full;
  assign io_deq_valid = (count_q != '0);
  assign io_deq_bits  = mem_q[rptr_q];
  assign io_count     = count_q;
  assign io_ip_txwm   = (count_q < {1'b0, io_txcnt});

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;
  assign wr_en  = do_enq & ~io_flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (io_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) wptr_d = wptr_q + PTR_ONE;
      if (do_deq) rptr_d = rptr_q + PTR_ONE;
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // One write enable per entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wptr_q == PW'(i))) mem_d[i] = io_enq_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: tb/tb_sirv_uart_txq.sv
// Self-checking bench for sirv_uart_txq.
// Table vectors, directed corner sequences, random vs queue model.
module tb_sirv_uart_txq;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       io_flush;
  logic       io_enq_valid;
  logic       io_enq_ready;
  logic [7:0] io_enq_bits;
  logic       io_deq_valid;
  logic       io_deq_ready;
  logic [7:0] io_deq_bits;
  logic [3:0] io_count;
  logic [2:0] io_txcnt;
  logic       io_full;
  logic       io_ip_txwm;

  always #5 clock = ~clock;

  sirv_uart_txq dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .io_flush     (io_flush),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_count     (io_count),
    .io_txcnt     (io_txcnt),
    .io_full      (io_full),
    .io_ip_txwm   (io_ip_txwm)
  );

  int passed = 0;
  int total  = 0;
  bit model_on = 1'b0;
  logic [7:0] mq[$];

  typedef struct {
    logic       ev;
    logic [7:0] eb;
    logic       dr;
    logic [3:0] cnt;
    logic       vld;
    logic [7:0] bits;
    logic       rdy;
    logic       full;
    logic       ip;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic ev,
                       input logic [7:0] eb, input logic dr,
                       input logic [2:0] tc);
    rst_n        = r;
    io_flush     = f;
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    io_txcnt     = tc;
  endtask

  // One clock: drive, compare with model, take the edge, update model.
  task automatic cycle(input logic r, input logic f, input logic ev,
                       input logic [7:0] eb, input logic dr,
                       input logic [2:0] tc);
    bit m_enq, m_deq;
    int sz;
    drive(r, f, ev, eb, dr, tc);
    #1;
    sz = mq.size();
    if (model_on) begin
      chk("m_count", io_count, sz);
      chk("m_valid", io_deq_valid, sz != 0);
      chk("m_full", io_full, sz == DEPTH);
      chk("m_ready", io_enq_ready, sz != DEPTH);
      chk("m_ip", io_ip_txwm, sz < int'(tc));
      if (sz != 0) chk("m_bits", io_deq_bits, mq[0]);
    end
    @(posedge clock);
    m_deq = (sz != 0) && dr;
    m_enq = ev && (sz < DEPTH);
    if (!r || f) mq.delete();
    else begin
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(eb);
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i] = '{ev: 1'b0, eb: 8'h00, dr: 1'b0, cnt: 4'd0, vld: 1'b0,
                 bits: 8'h00, rdy: 1'b1, full: 1'b0, ip: 1'b1};
      if (i < 8) begin
        tbl[i].ev   = 1'b1;
        tbl[i].eb   = 8'h41 + 8'(i);
        tbl[i].cnt  = 4'(i);
        tbl[i].vld  = (i != 0);
        tbl[i].bits = 8'h41;
        tbl[i].ip   = (i == 0);
      end else if (i == 8) begin
        tbl[i].ev   = 1'b1;
        tbl[i].eb   = 8'h49;
        tbl[i].cnt  = 4'd8;
        tbl[i].vld  = 1'b1;
        tbl[i].bits = 8'h41;
        tbl[i].rdy  = 1'b0;
        tbl[i].full = 1'b1;
        tbl[i].ip   = 1'b0;
      end else if (i < 17) begin
        tbl[i].dr   = 1'b1;
        tbl[i].cnt  = 4'(17 - i);
        tbl[i].vld  = 1'b1;
        tbl[i].bits = 8'h41 + 8'(i - 9);
        tbl[i].rdy  = (i != 9);
        tbl[i].full = (i == 9);
        tbl[i].ip   = 1'b0;
      end
    end

    // Reset held two cycles with txcnt = 1
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1);
    mq.delete();
    model_on = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1);
    #1;
    chk("rst_count", io_count, 0);
    chk("rst_valid", io_deq_valid, 0);
    chk("rst_ready", io_enq_ready, 1);
    chk("rst_full", io_full, 0);
    chk("rst_ip", io_ip_txwm, 1);

    // Fill, overflow write, drain
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, tbl[i].ev, tbl[i].eb, tbl[i].dr, 3'd1);
      #1;
      chk($sformatf("tbl%0d_cnt", i), io_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_vld", i), io_deq_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_rdy", i), io_enq_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_full", i), io_full, tbl[i].full);
      chk($sformatf("tbl%0d_ip", i), io_ip_txwm, tbl[i].ip);
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_bits", i), io_deq_bits, tbl[i].bits);
      cycle(1'b1, 1'b0, tbl[i].ev, tbl[i].eb, tbl[i].dr, 3'd1);
    end

    // Concurrent enq/deq at count 3 across pointer wrap
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 3'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, 3'd0);
      chk("conc_cnt", io_count, 3);
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
    chk("conc_empty", io_count, 0);

    // Empty: no bypass
    drive(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 3'd0);
    #1;
    chk("nobyp_wr_vld", io_deq_valid, 0);
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
    #1;
    chk("nobyp_vld", io_deq_valid, 1);
    chk("nobyp_bits", io_deq_bits, 8'h55);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);
    chk("nobyp_gone", io_count, 0);

    // Watermark
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h60 + 8'(k), 1'b0, 3'd4);
      #1;
      chk($sformatf("wm_c%0d", k), io_ip_txwm, k < 4);
      cycle(1'b1, 1'b0, 1'b1, 8'h60 + 8'(k), 1'b0, 3'd4);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4);
    #1;
    chk("wm_c6", io_ip_txwm, 0);
    io_txcnt = 3'd7;
    #1;
    chk("wm_txcnt7", io_ip_txwm, 1);
    io_txcnt = 3'd0;
    #1;
    chk("wm_txcnt0", io_ip_txwm, 0);
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2);

    // Flush with concurrent enqueue at count 5
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b0, 1'b1, 8'h70 + 8'(k), 1'b0, 3'd3);
    chk("fl_pre", io_count, 5);
    cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 3'd3);
    chk("fl_cnt", io_count, 0);
    chk("fl_vld", io_deq_valid, 0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3);
    chk("fl_cnt2", io_count, 0);

    // Same setup, mid-operation reset
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b0, 1'b1, 8'h80 + 8'(k), 1'b0, 3'd3);
    chk("mr_pre", io_count, 5);
    cycle(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 3'd3);
    chk("mr_cnt", io_count, 0);
    chk("mr_vld", io_deq_valid, 0);
    chk("mr_rdy", io_enq_ready, 1);
    chk("mr_ip", io_ip_txwm, 1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3);
    chk("mr_cnt2", io_count, 0);

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 60,
            8'($urandom),
            $urandom_range(0, 99) < 45,
            3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sirv_uart_txq.md
# sirv_uart_txq

Transmit queue between the UART register interface and `sirv_uarttx`. It buffers bytes written to the txdata register and presents them first-word-fall-through on a ready/valid port wired directly to the transmitter's `io_in_*`. It also supplies the txdata full flag and the transmit-watermark interrupt-pending bit.

## Interface

Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `WIDTH`, 8: data width.
- `CNTW`, log2(DEPTH)+1: occupancy counter width.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `io_flush` in 1: synchronous queue clear.
- `io_enq_valid` in 1: byte write strobe from the register block.
- `io_enq_ready` out 1: queue can accept a byte (not full).
- `io_enq_bits` in WIDTH: byte to enqueue.
- `io_deq_valid` out 1: head entry valid; connects to `io_in_valid` of `sirv_uarttx`.
- `io_deq_ready` in 1: consumer accepts the head; connects to `io_in_ready` of `sirv_uarttx`.
- `io_deq_bits` out WIDTH: head entry.
- `io_count` out CNTW: current occupancy, 0..DEPTH.
- `io_txcnt` in CNTW-1: watermark level.
- `io_full` out 1: occupancy equals DEPTH; readback bit 31 of txdata.
- `io_ip_txwm` out 1: watermark pending, high when `io_count < io_txcnt`.

## Operation

- **Storage**
  - Flop array of DEPTH × WIDTH.
  - Write pointer and read pointer are log2(DEPTH) bits each and wrap naturally modulo DEPTH.
  - Occupancy counter is CNTW bits.
- **Enqueue**
  - `io_enq_ready = !io_full`.
  - On `io_enq_valid & io_enq_ready`, `io_enq_bits` is written at the write pointer and the write pointer advances.
  - A write while full is dropped silently; no state changes.
- **Dequeue**
  - `io_deq_valid = (count != 0)`.
  - `io_deq_bits = mem[rptr]`, combinational from registered state.
  - On `io_deq_valid & io_deq_ready`, the read pointer advances.
- **Count update**
  - +1 on enqueue only, -1 on dequeue only, unchanged when both or neither occur.
- **Simultaneous enqueue and dequeue**
  - Both are legal whenever `0 < count < DEPTH`; count holds.
  - When empty, an enqueue does not bypass to the output: `io_deq_valid` rises the next cycle.
  - When full, enqueue is refused (`io_enq_ready` = 0), so only the dequeue takes effect.
- **Flush**
  - Pointers and count go to 0 at the next edge.
  - Flush overrides any enqueue or dequeue in the same cycle.
  - Memory contents are not cleared.
- **Watermark**
  - `io_ip_txwm = (io_count < {1'b0, io_txcnt})`, combinational.
  - `io_txcnt = 0` keeps the bit permanently low.
  - `io_txcnt` changes take effect in the same cycle.
- **Reset** (`rst_n` = 0 at an edge), including mid-operation:
  - Pointers and count are set to 0; memory contents are not reset.
  - Outputs after reset: `io_deq_valid` = 0, `io_enq_ready` = 1, `io_full` = 0, `io_count` = 0, `io_ip_txwm` = (`io_txcnt` != 0).
  - Any byte in flight is lost.

## Timing

- Enqueue-to-head latency is 1 cycle: a byte written at edge N is visible on `io_deq_*` after edge N.
- Dequeue takes effect at the accepting edge; the next head is presented in the same cycle after that edge.
- A full queue can accept again in the cycle after a dequeue.
- No combinational path from `io_enq_valid` to `io_deq_valid`.
- No combinational path from `io_deq_ready` to `io_enq_ready`.
- The only input-to-output combinational path is `io_txcnt` → `io_ip_txwm`.

## Structure

- `UART_DATA_W` (8) and `UART_TXQ_DEPTH` (8) belong in the shared UART package alongside the rxq constants, so the tx and rx queues and the register block agree.
- No sub-module: pointers, counter and flop array are held inline, and the array is written with one enable per entry.
- Top-level UART instantiates this block, with `io_deq_*` connected straight to `sirv_uarttx` `io_in_*`.

## Test plan

1. **Reset**: hold `rst_n` = 0 for 2 cycles with `io_txcnt` = 1, then release. Required: `io_count` = 0, `io_deq_valid` = 0, `io_enq_ready` = 1, `io_ip_txwm` = 1.
2. **Fill and order**: enqueue 0x41..0x48 back-to-back with `io_deq_ready` = 0. Required: `io_full` = 1 and `io_enq_ready` = 0 after the 8th byte. A 9th write of 0x49 is dropped. Then drain with `io_deq_ready` = 1. Required output order 0x41..0x48, `io_count` reaching 0, no 0x49.
3. **Concurrent enqueue/dequeue**: at count = 3, assert both enqueue and dequeue for 20 cycles. Required: count stays at 3 throughout, and data passes in FIFO order across pointer wrap.
4. **Empty no-bypass**: with the queue empty and `io_deq_ready` = 1, enqueue 0x55. Required: `io_deq_valid` = 0 in the write cycle, 1 with bits 0x55 in the next cycle, dequeued in that cycle.
5. **Watermark**: set `io_txcnt` = 4 and enqueue 6 bytes. Required: `io_ip_txwm` = 1 while count is 0..3, 0 at counts 4..6. Change `io_txcnt` to 7. Required: `io_ip_txwm` = 1 in the same cycle.
6. **Flush and mid-operation reset**: at count = 5, assert `io_flush` together with an enqueue. Required: count = 0 next cycle and the enqueued byte is discarded. Repeat the setup using `rst_n` = 0 instead of flush. Required: identical result.
